// File: rtl/emg_request_conditioner.sv
// Emergency request conditioner: sync, debounce, minimum hold and cooldown
// in front of the traffic light controller's emg input.
module emg_request_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 15,
  parameter int COOLDOWN_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       emg_raw,
  output logic       emg,
  output logic       busy,
  output logic [7:0] event_cnt
);

  localparam int M1 =
    (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
    DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CMAX =
    (M1 > COOLDOWN_CYCLES) ?
    M1 : COOLDOWN_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DB_N  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HLD_N = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CD_N  = CW'(COOLDOWN_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ACTIVE,
    COOLDOWN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  state_t                 state_d;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_d;
  logic                   evt_inc;
  logic                   emg_d;
  logic                   busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], emg_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    evt_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_d = DEBOUNCE;
          cnt_d   = ONE;
        end
      end
      DEBOUNCE: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DB_N) begin
          state_d = ACTIVE;
          cnt_d   = ONE;
          evt_inc = 1'b1;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      ACTIVE: begin
        // cnt parks at HOLD so a held input keeps emg up
        if (cnt == HLD_N) begin
          if (!s) begin
            state_d = COOLDOWN;
            cnt_d   = ONE;
          end
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      COOLDOWN: begin
        if (cnt == CD_N) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
    endcase
  end

  always_comb begin
    emg_d  = (state_d == ACTIVE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emg  <= 1'b0;
      busy <= 1'b0;
    end else begin
      emg  <= emg_d;
      busy <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt <= '0;
    end else if (evt_inc && event_cnt != 8'hFF) begin
      event_cnt <= event_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_emg_request_conditioner.sv
// Scoreboard bench for emg_request_conditioner: expected emg/busy edges
// are queued by the stimulus and checked by an edge monitor.
module tb_emg_request_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       emg_raw = 1'b1;
  logic       emg;
  logic       busy;
  logic [7:0] event_cnt;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int at;
    int val;
    int cnt;
  } exp_t;

  exp_t q_emg[$];
  exp_t q_busy[$];
  exp_t xe;
  exp_t xb;
  logic pe = 1'b0;
  logic pb = 1'b0;

  emg_request_conditioner dut (
    .clk(clk),
    .rst_n(rst_n),
    .emg_raw(emg_raw),
    .emg(emg),
    .busy(busy),
    .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_e(input int at, input int v, input int c);
    q_emg.push_back('{at, v, c});
  endtask

  task automatic push_b(input int at, input int v);
    q_busy.push_back('{at, v, 0});
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(input int h);
    int e;
    e = cyc;
    emg_raw = 1'b1;
    wait_to(e + h);
    emg_raw = 1'b0;
  endtask

  // edge monitor: every change of emg/busy must match the queue head
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pe = emg;
      pb = busy;
    end else begin
      if (emg !== pe) begin
        if (q_emg.size() == 0) begin
          total++;
          bad++;
          $display("FAIL emg_unexpected: edge to %0b at cyc %0d",
                   emg, cyc);
        end else begin
          xe = q_emg.pop_front();
          chk("emg_edge_cyc", cyc, xe.at);
          chk("emg_level", int'(emg), xe.val);
          chk("event_cnt_at_emg", int'(event_cnt), xe.cnt);
        end
        pe = emg;
      end
      if (busy !== pb) begin
        if (q_busy.size() == 0) begin
          total++;
          bad++;
          $display("FAIL busy_unexpected: edge to %0b at cyc %0d",
                   busy, cyc);
        end else begin
          xb = q_busy.pop_front();
          chk("busy_edge_cyc", cyc, xb.at);
          chk("busy_level", int'(busy), xb.val);
        end
        pb = busy;
      end
    end
  end

  initial begin
    int e;
    int c;

    // reset held with the input already high
    wait_to(10);
    chk("rst_emg", int'(emg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_event_cnt", int'(event_cnt), 0);
    e = cyc;
    push_b(e + 3, 1);
    push_e(e + 7, 1, 1);
    push_e(e + 22, 0, 1);
    push_b(e + 54, 0);
    rst_n = 1'b1;
    wait_to(e + 10);
    emg_raw = 1'b0;
    wait_to(e + 60);

    // glitch of 3 cycles
    e = cyc;
    push_b(e + 3, 1);
    push_b(e + 6, 0);
    press(3);
    wait_to(e + 12);
    chk("glitch_event_cnt", int'(event_cnt), 1);

    // short press: minimum hold then cooldown
    e = cyc;
    push_b(e + 3, 1);
    push_e(e + 7, 1, 2);
    push_e(e + 22, 0, 2);
    push_b(e + 54, 0);
    press(6);
    wait_to(e + 60);

    // long hold: emg follows raw fall by 3 edges
    e = cyc;
    push_b(e + 3, 1);
    push_e(e + 7, 1, 3);
    push_e(e + 43, 0, 3);
    push_b(e + 75, 0);
    press(40);
    wait_to(e + 80);

    // press inside cooldown is ignored
    e = cyc;
    push_b(e + 3, 1);
    push_e(e + 7, 1, 4);
    push_e(e + 22, 0, 4);
    push_b(e + 54, 0);
    press(6);
    wait_to(e + 30);
    press(5);
    wait_to(e + 60);
    chk("lockout_event_cnt", int'(event_cnt), 4);
    chk("lockout_busy", int'(busy), 0);

    // input held across cooldown end: IDLE, then 5 more edges to emg
    e = cyc;
    push_b(e + 3, 1);
    push_e(e + 7, 1, 5);
    push_e(e + 22, 0, 5);
    push_b(e + 54, 0);
    push_b(e + 55, 1);
    push_e(e + 59, 1, 6);
    push_e(e + 74, 0, 6);
    push_b(e + 106, 0);
    press(6);
    wait_to(e + 40);
    emg_raw = 1'b1;
    wait_to(e + 65);
    emg_raw = 1'b0;
    wait_to(e + 112);

    // drive event_cnt into saturation
    for (int i = 0; i < 252; i++) begin
      c = (7 + i > 255) ? 255 : 7 + i;
      e = cyc;
      push_b(e + 3, 1);
      push_e(e + 7, 1, c);
      push_e(e + 22, 0, c);
      push_b(e + 54, 0);
      press(6);
      wait_to(e + 56);
    end
    chk("sat_event_cnt", int'(event_cnt), 255);

    // async reset between edges, 5 cycles into ACTIVE
    e = cyc;
    push_b(e + 3, 1);
    push_e(e + 7, 1, 255);
    press(6);
    wait_to(e + 12);
    chk("pre_rst_emg", int'(emg), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_emg", int'(emg), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_event_cnt", int'(event_cnt), 0);
    wait_to(e + 17);
    rst_n = 1'b1;
    wait_to(e + 47);
    chk("post_rst_emg", int'(emg), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_event_cnt", int'(event_cnt), 0);

    chk("emg_queue_left", q_emg.size(), 0);
    chk("busy_queue_left", q_busy.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
